// File: rtl/aes_session_pkg.sv
// Shared types and constants for the masked-AES session sequencer.
package aes_session_pkg;
    typedef enum logic [1:0] {IDLE, FEED, RUN} state_e;

    localparam int BLOCK_BYTES = 16;
    localparam int IDX_W       = $clog2(BLOCK_BYTES);
    localparam int DONE_FIRST  = 245;
    localparam int DONE_LEN    = 16;
endpackage

// File: rtl/aes_byte_block_buf.sv
// One AES block of shared bytes: indexed write, combinational indexed read, synchronous clear.
module aes_byte_block_buf
    import aes_session_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [W-1:0]     rdata_o
);
    logic [BLOCK_BYTES-1:0][W-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (clr_i)     mem_q <= '0;
        else if (we_i) mem_q[widx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/aes_session_ctrl.sv
// Session sequencer: buffers a shared pt/key block, feeds the byte-serial core,
// captures its done window into the ciphertext buffer and streams it out.
module aes_session_ctrl
    import aes_session_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int TIMEOUT = 300
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*SHARES-1:0] in_pt,
    input  logic [8*SHARES-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*SHARES-1:0] out_ct,
    output logic                out_last,
    output logic                core_rst,
    output logic [8*SHARES-1:0] core_pt,
    output logic [8*SHARES-1:0] core_key,
    input  logic                core_done,
    input  logic [8*SHARES-1:0] core_ct,
    input  logic                rng_seeded,
    output logic                rng_en,
    output logic                busy,
    output logic                err
);
    localparam int W   = 8*SHARES;
    localparam int WDW = $clog2(TIMEOUT+1);
    localparam logic [4:0] BB = 5'(BLOCK_BYTES);

    state_e           state_q, state_d;
    logic [4:0]       in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, cap_cnt_q, cap_cnt_d;
    logic [IDX_W-1:0] feed_q, feed_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic             err_q, err_d, err_evt;
    logic             in_fire, out_fire, cap_we;
    logic [2*W-1:0]   in_rd;

    assign in_ready  = (in_cnt_q < BB) && (state_q != FEED);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (out_cnt_q != 5'd0);
    assign out_last  = (out_cnt_q == 5'd1);
    assign out_fire  = out_valid && out_ready;
    assign cap_we    = (state_q == RUN) && core_done;
    assign busy      = (state_q != IDLE);
    assign rng_en    = busy;
    assign err       = err_q;
    // Start pulse: core held in reset while idle and during F0 only.
    assign core_rst  = (state_q == IDLE) || (state_q == FEED && feed_q == '0);
    assign core_pt   = (state_q == FEED) ? in_rd[2*W-1:W] : '0;
    assign core_key  = (state_q == FEED) ? in_rd[W-1:0]   : '0;

    aes_byte_block_buf #(.W(2*W)) u_in_buf (
        .clk_i   (clk),
        .clr_i   (rst),
        .we_i    (in_fire),
        .widx_i  (in_cnt_q[IDX_W-1:0]),
        .wdata_i ({in_pt, in_key}),
        .ridx_i  (feed_q),
        .rdata_o (in_rd)
    );

    aes_byte_block_buf #(.W(W)) u_ct_buf (
        .clk_i   (clk),
        .clr_i   (rst || err_evt),
        .we_i    (cap_we),
        .widx_i  (cap_cnt_q[IDX_W-1:0]),
        .wdata_i (core_ct),
        .ridx_i  (IDX_W'(BB - out_cnt_q)),
        .rdata_o (out_ct)
    );

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        cap_cnt_d = cap_cnt_q;
        feed_d    = feed_q;
        wdog_d    = wdog_q;
        err_d     = err_q;
        err_evt   = 1'b0;
        if (in_fire)  in_cnt_d  = in_cnt_q + 5'd1;
        if (out_fire) out_cnt_d = out_cnt_q - 5'd1;
        case (state_q)
            IDLE: begin
                // Registered out_cnt: the final output beat enables FEED one cycle later.
                if (in_cnt_q == BB && out_cnt_q == 5'd0 && rng_seeded && !err_q) begin
                    state_d   = FEED;
                    feed_d    = '0;
                    wdog_d    = '0;
                    cap_cnt_d = 5'd0;
                end
            end
            FEED: begin
                wdog_d = wdog_q + WDW'(1);
                feed_d = feed_q + IDX_W'(1);
                if (feed_q == IDX_W'(BLOCK_BYTES-1)) begin
                    in_cnt_d = 5'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (wdog_q != '1) wdog_d = wdog_q + WDW'(1);
                if (core_done) begin
                    cap_cnt_d = cap_cnt_q + 5'd1;
                    if (cap_cnt_q == BB - 5'd1) begin
                        cap_cnt_d = 5'd0;
                        out_cnt_d = BB;
                        state_d   = IDLE;
                    end
                end else if (cap_cnt_q != 5'd0 || wdog_q == WDW'(TIMEOUT-1)) begin
                    err_evt   = 1'b1;
                    err_d     = 1'b1;
                    cap_cnt_d = 5'd0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_cnt_q  <= 5'd0;
            out_cnt_q <= 5'd0;
            cap_cnt_q <= 5'd0;
            feed_q    <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            feed_q    <= feed_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_aes_session_ctrl.sv
// Directed bench for aes_session_ctrl with a behavioural core whose done window is selectable.
module tb_aes_session_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic        core_rst, core_done, rng_seeded, rng_en, busy, err;
    logic [15:0] in_pt, in_key, out_ct, core_pt, core_key, core_ct;
    int          cyc = 0;
    int          core_mode;
    int          n_vec = 0, n_err = 0;
    logic [7:0]  c8;

    always #5 clk = ~clk;

    aes_session_ctrl #(.SHARES(2), .TIMEOUT(300)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
        .out_ct(out_ct), .out_last(out_last), .core_rst(core_rst), .core_pt(core_pt),
        .core_key(core_key), .core_done(core_done), .core_ct(core_ct),
        .rng_seeded(rng_seeded), .rng_en(rng_en), .busy(busy), .err(err)
    );

    // Core model: cyc = k-1 at F0+k; mode 0 nominal, 1 never done, 2 drops after 7 bytes.
    always @(posedge clk) begin
        if (core_rst) cyc <= 0;
        else          cyc <= cyc + 1;
    end
    assign c8        = 8'(cyc);
    assign core_ct   = {c8, ~c8};
    assign core_done = (core_mode == 0 && cyc >= 244 && cyc <= 259) ||
                       (core_mode == 2 && cyc >= 244 && cyc <= 250);

    function automatic logic [15:0] pt_of(int b, int j);
        logic [7:0] v;
        v = 8'(16*b + j);
        return {v, v ^ 8'hC3};
    endfunction

    function automatic logic [15:0] key_of(int b, int j);
        logic [7:0] v;
        v = 8'(8'h5A + 3*j + b);
        return {8'(j*7), v};
    endfunction

    function automatic logic [15:0] ct_of(int j);
        logic [7:0] c;
        c = 8'(244 + j);
        return {c, ~c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input int b, input int j);
        int k;
        in_valid = 1'b1;
        in_pt    = pt_of(b, j);
        in_key   = key_of(b, j);
        k = 0;
        while (!in_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("in_handshake", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_block(input int b);
        for (int j = 0; j < 16; j++) send_byte(b, j);
    endtask

    task automatic wait_f0();
        for (int k = 0; k < 1000 && !busy; k++) @(negedge clk);
        chk("f0_seen", busy, 1);
    endtask

    task automatic drain();
        for (int j = 0; j < 16; j++) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_ct", out_ct, ct_of(j));
            chk("beat_last", out_last, (j == 15));
            step(1);
        end
        chk("drained", out_valid, 0);
    endtask

    task automatic run_block(input int b);
        push_block(b);
        wait_f0();
        for (int i = 0; i < 16; i++) begin
            chk("feed_pt", core_pt, pt_of(b, i));
            chk("feed_key", core_key, key_of(b, i));
            chk("feed_rst", core_rst, (i == 0));
            step(1);
        end
        chk("run_rst", core_rst, 0);
        chk("run_pt_zero", core_pt, 0);
        step(244);
        chk("pre_out_valid", out_valid, 0);
        chk("pre_out_busy", busy, 1);
        step(1);
        chk("post_cap_idle", busy, 0);
        drain();
        chk("blk_err", err, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rng_en", rng_en, 0);
        chk("rst_core_pt", core_pt, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pt = '0; in_key = '0;
        out_ready = 1'b1; rng_seeded = 1'b1; core_mode = 0;
        step(3);
        chk_reset_outs();
        rst = 1'b0;

        // Single nominal block
        run_block(0);

        // Preload during RUN, output backpressure for 50 cycles
        out_ready = 1'b0;
        push_block(1);
        wait_f0();
        chk("feed_in_ready", in_ready, 0);
        step(16);
        for (int j = 0; j < 16; j++) begin
            chk("preload_ready", in_ready, 1);
            chk("preload_busy", busy, 1);
            in_valid = 1'b1; in_pt = pt_of(2, j); in_key = key_of(2, j);
            step(1);
        end
        in_valid = 1'b0;
        chk("preload_full", in_ready, 0);
        step(229);
        chk("bp_valid0", out_valid, 1);
        chk("bp_ct0", out_ct, ct_of(0));
        step(50);
        chk("bp_valid1", out_valid, 1);
        chk("bp_ct1", out_ct, ct_of(0));
        chk("bp_no_feed", busy, 0);
        out_ready = 1'b1;
        drain();
        chk("no_same_cycle_feed", busy, 0);
        step(1);
        chk("f0_after_drain", busy, 1);
        chk("f0_after_drain_rst", core_rst, 1);
        chk("f0_after_drain_pt", core_pt, pt_of(2, 0));
        step(261);
        drain();

        // rng not seeded holds IDLE; then a core that never finishes times out
        rng_seeded = 1'b0;
        push_block(3);
        step(5);
        chk("noseed_busy", busy, 0);
        chk("noseed_rng_en", rng_en, 0);
        chk("noseed_core_rst", core_rst, 1);
        core_mode  = 1;
        rng_seeded = 1'b1;
        step(1);
        chk("seed_feed", busy, 1);
        chk("seed_rng_en", rng_en, 1);
        step(299);
        chk("wdog_pre_err", err, 0);
        chk("wdog_pre_busy", busy, 1);
        step(1);
        chk("wdog_err", err, 1);
        chk("wdog_core_rst", core_rst, 1);
        chk("wdog_busy", busy, 0);
        chk("wdog_out_valid", out_valid, 0);
        push_block(4);
        step(20);
        chk("err_no_feed", busy, 0);
        chk("err_in_full", in_ready, 0);
        chk("err_sticky", err, 1);
        chk("err_no_out", out_valid, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("err_cleared", err, 0);

        // core_done drops after 7 bytes
        core_mode = 2;
        push_block(5);
        wait_f0();
        step(252);
        chk("drop_pre_err", err, 0);
        chk("drop_pre_busy", busy, 1);
        step(1);
        chk("drop_err", err, 1);
        chk("drop_out_valid", out_valid, 0);
        chk("drop_busy", busy, 0);
        step(20);
        chk("drop_no_partial", out_valid, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // Reset mid-RUN, then a clean block
        core_mode = 0;
        push_block(6);
        wait_f0();
        step(100);
        chk("midrun_busy", busy, 1);
        rst = 1'b1;
        step(1);
        chk_reset_outs();
        rst = 1'b0;
        run_block(7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
